// File: rtl/clkmeas.sv
// clkmeas: synchronises a slow input, decodes rise/fall strobes and measures its period.
// Define CLKMEAS_DUTY_EN to also measure high time per period.
module clkmeas #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    input  logic             ready,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("clkmeas: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sig_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   overrun_q, overrun_d;
    logic                   cap;

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~prev_q;
    assign fall  = ~sig_s & prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sig_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        cap       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = CNT_ONE;
                end
            end
            MEAS: begin
                // A rise on the saturated count is still a valid capture.
                if (rise) begin
                    cap   = 1'b1;
                    cnt_d = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_comb begin
        period_d  = period_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (cap) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef CLKMEAS_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hlast_q, hlast_d;
    logic [CNT_W-1:0] high_q, high_d;

    // hcnt counts the rise cycle itself, matching how cnt restarts at 1.
    always_comb begin
        hcnt_d  = hcnt_q;
        hlast_d = hlast_q;
        high_d  = high_q;
        if (rise) begin
            hcnt_d = CNT_ONE;
        end else if (state_q == IDLE) begin
            hcnt_d = '0;
        end else if (sig_s && hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + CNT_ONE;
        end
        if (state_q == MEAS && fall) begin
            hlast_d = hcnt_q;
        end
        if (cap) begin
            high_d = hlast_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q  <= '0;
            hlast_q <= '0;
            high_q  <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            hlast_q <= hlast_d;
            high_q  <= high_d;
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign overrun = overrun_q;

endmodule
